rf_wport_arbiter: RTL
=====================

Name: rf_wport_arbiter

Overview:
- Round-robin arbiter sharing the single register-file write port among up to NUM_REQ writeback requesters: ALU writeback, load/store unit, and debug/init loader.
- Sits between the execute/memory stages and the register file inside the RISC-V top level.
- Issues at most one registered write per cycle and returns a valid/ready handshake to each requester.
- Honours a pipeline-wide write-freeze input.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = ALU, 1 = LSU, 2 = debug.
- XLEN, 32, data width.
- AW, 5, register address width.
- CNT_W, 16, width of each stall counter (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- freeze  in  1  when high, no grants are made this cycle.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*AW  flattened destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NUM_REQ*XLEN  flattened write data; requester i occupies bits [i*XLEN +: XLEN].
- req_ready  out  NUM_REQ  one-hot grant; combinational from the current-cycle inputs.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  AW  register-file write address (registered).
- rf_wdata  out  XLEN  register-file write data (registered).
- wb_valid  out  1  a grant occurred last cycle, including x0 writes.
- wb_id  out  3  index of last cycle's granted requester.
- stall_cnt  out  NUM_REQ*CNT_W  per-requester stall counters.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, wb_valid=0, wb_id=0.
  - Priority pointer ptr=0; stall_cnt all 0.
  - req_ready=0 whenever rst_n=0.
- Grant (combinational):
  - If freeze=0 and any req_valid is set, grant the first set bit found scanning from ptr upward, modulo NUM_REQ.
  - req_ready is one-hot at that index; all other bits are 0.
  - With freeze=1 or no valid requests, req_ready=0.
- Transfer: occurs when req_valid[i] && req_ready[i] at the edge.
- Pointer:
  - On a transfer from i, ptr <= (i+1) mod NUM_REQ.
  - With no transfer, ptr holds.
- Latency: request accepted at edge N produces rf_we/rf_waddr/rf_wdata valid during cycle N+1; the RF commits at edge N+1.
- Max throughput: one write per cycle. Back-to-back grants to the same requester are allowed when it is the only one valid.
- x0 writes:
  - A transfer with addr=0 is accepted normally and sets wb_valid=1 and wb_id.
  - rf_we stays 0 for that write.
- No transfer in a cycle: next cycle rf_we=0, wb_valid=0. rf_waddr and rf_wdata hold their previous values.
- Requester contract (the arbiter does not check it): once valid is raised, addr/data stay stable and valid stays high until accepted.
- Freeze:
  - Applies the same cycle it is asserted.
  - Does not cancel the write already registered on rf_we.
- Reset mid-operation: a pending registered write is dropped (rf_we=0 the following cycle); requesters must re-present.
- NUM_REQ=2: wb_id upper bits are 0.

Optional Feature:
- Macro RF_ARB_STALL_CNT_EN.
- Defined:
  - stall_cnt[i] increments each cycle that req_valid[i]=1 && req_ready[i]=0, including freeze cycles.
  - Counters saturate at 2^CNT_W-1.
  - Cleared only by reset.
- Undefined: stall_cnt is driven constant 0 and no counter flops are built.

Decomposition:
- Shared package/header rv_pkg holds:
  - XLEN=32 and REG_AW=5.
  - Requester index constants REQ_ALU=0, REQ_LSU=1, REQ_DBG=2.
  - Register constant X0=0.
- One sub-module, rr_picker: combinational NUM_REQ-wide round-robin picker, with inputs req vector and ptr and a one-hot grant output.
- The top holds ptr, the output registers and the counters.

Test Plan:
- Reset with all req_valid=1 → req_ready=0 during reset. First cycle after release, req_ready=3'b001 (ALU, ptr=0); ALU addr=3, data=30 → next cycle rf_we=1, rf_waddr=3, rf_wdata=30, wb_id=0.
- All three valid continuously for 6 cycles → grant order 0,1,2,0,1,2. wb_id sequence lags by one cycle.
- Only LSU valid for 3 cycles, addr=5, data=0x1234 → three consecutive rf_we pulses to x5. ptr ends at 2.
- DBG writes addr=0, data=0xFFFF_FFFF → wb_valid=1, wb_id=2, rf_we=0.
- freeze=1 for 2 cycles with ALU and LSU valid → req_ready=0 for those cycles; stall_cnt ALU=2, LSU=2 with RF_ARB_STALL_CNT_EN, else 0. After freeze drops, the ALU is granted first.
- Pulse rst_n=0 the cycle after a grant → rf_we=0 the next cycle, ptr=0, and counters cleared.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V core constants: data/address widths, writeback requester indices, x0.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_DBG = 2;

  localparam int unsigned X0 = 0;

endpackage

// File: rtl/rf_wport_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first request at or after ptr.
module rr_picker
  import rv_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW:0] pos;
  logic        found;

  // pos walks ptr, ptr+1, ... wrapping at N; one extra bit keeps the wrap compare exact
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter for the single register-file write port with freeze support.
// Optional per-requester stall counters enabled by defining RF_ARB_STALL_CNT_EN.
module rf_wport_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = rv_pkg::XLEN,
  parameter int unsigned AW      = rv_pkg::REG_AW,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     freeze,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*XLEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     wb_valid,
  output logic [2:0]               wb_id,
  output logic [NUM_REQ*CNT_W-1:0] stall_cnt
);

  import rv_pkg::*;

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      sel_idx;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;
  logic               xfer;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = (rst_n && !freeze) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req_ready[j]) begin
        sel_idx  = PW'(j);
        sel_addr = req_addr[j*AW +: AW];
        sel_data = req_data[j*XLEN +: XLEN];
      end
    end
    ptr_next = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);
  end

  // x0 transfers still update wb_valid/wb_id but never raise rf_we
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_valid <= 1'b0;
      wb_id    <= '0;
    end else if (xfer) begin
      ptr      <= ptr_next;
      rf_we    <= (sel_addr != AW'(X0));
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
      wb_valid <= 1'b1;
      wb_id    <= 3'(sel_idx);
    end else begin
      rf_we    <= 1'b0;
      wb_valid <= 1'b0;
    end
  end

`ifdef RF_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stall_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) stall_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
